// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem read at a time, results presented to decode from a small buffer.
// Build option FETCH_SKID_BUF_EN adds a skid entry behind the output register (2-entry buffer).
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro
);
    // Handshakes: imem_req_o/imem_addr_o hold until the cycle imem_ack_i=1 (ack only counts while
    // req is high); decode takes an instruction on any cycle with valid_ro & ready_i.
    typedef enum logic [1:0] {RUN, WAIT, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        pop;
    logic        push;
    logic        space;

`ifdef FETCH_SKID_BUF_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    // The skid entry is only ever occupied behind a full output register.
    assign space = !skid_valid_q || ready_i;
`else
    assign space = !valid_q || ready_i;
`endif

    assign pop = valid_q && ready_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        push        = 1'b0;
        unique case (state_q)
            RUN: begin
                imem_req_o = space && !redirect_i;
                if (imem_req_o) begin
                    if (imem_ack_i) push = 1'b1;
                    else            state_d = WAIT;
                end
            end
            WAIT: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    push    = !redirect_i;
                    state_d = RUN;
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The stale request keeps its original address; pc_q may already point elsewhere.
                imem_req_o  = 1'b1;
                imem_addr_o = addr_q;
                if (imem_ack_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) imem_req_o = 1'b0;
        if (state_q != DROP) addr_d = pc_q;
        if (push) pc_d = pc_q + 32'd4;
        if (redirect_i) pc_d = redirect_pc_i & ~32'h3;
    end

    always_comb begin
        valid_d    = valid_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
`ifdef FETCH_SKID_BUF_EN
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
`endif
        if (redirect_i) begin
            valid_d = 1'b0;
`ifdef FETCH_SKID_BUF_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
            if (pop) valid_d = 1'b0;
`ifdef FETCH_SKID_BUF_EN
            if (pop && skid_valid_q) begin
                valid_d      = 1'b1;
                out_pc_d     = skid_pc_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = 1'b0;
            end
            if (push) begin
                if (!valid_d) begin
                    valid_d    = 1'b1;
                    out_pc_d   = pc_q;
                    out_inst_d = imem_rdata_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = pc_q;
                    skid_inst_d  = imem_rdata_i;
                end
            end
`else
            if (push) begin
                valid_d    = 1'b1;
                out_pc_d   = pc_q;
                out_inst_d = imem_rdata_i;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            out_pc_q   <= 32'd0;
            out_inst_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
        end
    end

`ifdef FETCH_SKID_BUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_inst_q  <= 32'd0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end
`endif

    assign valid_ro = valid_q;
    assign pc_ro    = out_pc_q;
    assign inst_ro  = out_inst_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus random traffic, checked against a queue-based model
// of the instruction stream and the one-outstanding-request memory protocol.
module tb_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_ro;
    logic        ready_i;
    logic [31:0] pc_ro;
    logic [31:0] inst_ro;
    logic        ack_en;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the stream decode should see, and the memory-side bookkeeping.
    logic [63:0] exp_q[$];
    logic [31:0] fetch_pc;
    logic [31:0] held_addr;
    bit          outstanding;
    bit          dropping;
    int          occ;
    bit          m_pop;
    bit          m_exp_req;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign imem_ack_i   = imem_req_o & ack_en;
    assign imem_rdata_i = inst_of(imem_addr_o);

    fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_ro      (valid_ro),
        .ready_i       (ready_i),
        .pc_ro         (pc_ro),
        .inst_ro       (inst_ro)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else             n_pass++;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit ack, input bit rdy);
        @(posedge clk);
        #1;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        ack_en        = ack;
        ready_i       = rdy;
        @(negedge clk);
    endtask

    // Scoreboard / protocol monitor, sampling mid-cycle and then advancing the model over the edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req", 32'(imem_req_o), 32'd0);
            check("rst_valid", 32'(valid_ro), 32'd0);
            check("rst_pc_ro", pc_ro, 32'd0);
            check("rst_inst_ro", inst_ro, 32'd0);
            exp_q.delete();
            fetch_pc    = RESET_PC;
            outstanding = 1'b0;
            dropping    = 1'b0;
        end else begin
            m_pop = (exp_q.size() > 0) && ready_i;
            if (outstanding) begin
                check("req_hold", 32'(imem_req_o), 32'd1);
                check("addr_hold", imem_addr_o, held_addr);
            end else begin
                occ       = exp_q.size() - (m_pop ? 1 : 0);
                m_exp_req = !redirect_i && (occ < CAP);
                check("req_issue", 32'(imem_req_o), 32'(m_exp_req));
                if (m_exp_req) check("req_addr", imem_addr_o, fetch_pc);
            end
            check("valid", 32'(valid_ro), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("pc_ro", pc_ro, exp_q[0][63:32]);
                check("inst_ro", inst_ro, exp_q[0][31:0]);
            end
            if (redirect_i) begin
                exp_q.delete();
                fetch_pc    = redirect_pc_i & ~32'h3;
                outstanding = outstanding && !imem_ack_i;
                dropping    = outstanding;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (imem_req_o && imem_ack_i) begin
                    if (dropping) dropping = 1'b0;
                    else begin
                        exp_q.push_back({fetch_pc, inst_of(fetch_pc)});
                        fetch_pc = fetch_pc + 32'd4;
                    end
                    outstanding = 1'b0;
                end else if (imem_req_o && !outstanding) begin
                    outstanding = 1'b1;
                    held_addr   = fetch_pc;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ready_i = 1'b0; ack_en = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; ack_en = 1'b1; ready_i = 1'b1;

        // Streaming from reset with immediate acks.
        @(negedge clk);
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            check("seq_valid", 32'(valid_ro), 32'd1);
            check("seq_pc", pc_ro, RESET_PC + 32'(4 * k));
        end

        // Back-pressure for five cycles.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            check("bp_valid", 32'(valid_ro), 32'd1);
        end
        check("bp_req_off", 32'(imem_req_o), 32'd0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1);

        // Ack delayed three cycles.
        step(1'b1, 32'h40, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1);
            check("dly_req", 32'(imem_req_o), 32'd1);
            check("dly_addr", imem_addr_o, 32'h40);
            check("dly_valid", 32'(valid_ro), 32'd0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("dly_addr_ack", imem_addr_o, 32'h40);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("dly_valid_after", 32'(valid_ro), 32'd1);
        check("dly_pc", pc_ro, 32'h40);
        check("dly_inst", inst_ro, inst_of(32'h40));

        // Redirect while a request is outstanding: its data must be dropped.
        step(1'b1, 32'h10, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("drop_req_addr", imem_addr_o, 32'h10);
        step(1'b1, 32'h2003, 1'b0, 1'b1);
        check("drop_redir_req", 32'(imem_req_o), 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("drop_old_addr", imem_addr_o, 32'h10);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("drop_valid", 32'(valid_ro), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("drop_new_addr", imem_addr_o, 32'h2000);
        check("drop_no_data", 32'(valid_ro), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("drop_first_pc", pc_ro, 32'h2000);

        // Address wrap at the top of memory.
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("wrap_zero", imem_addr_o, 32'h0000_0000);

        // Reset while waiting on memory.
        step(1'b1, 32'h500, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("wait_addr", imem_addr_o, 32'h500);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(imem_req_o), 32'd0);
        check("mid_rst_valid", 32'(valid_ro), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(imem_req_o), 32'd1);
        check("post_rst_addr", imem_addr_o, RESET_PC);

        // Random traffic; the monitor carries all checks here.
        for (int k = 0; k < 2000; k++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 30) == 0, rpc, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0);
        end
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req_o  output  1  instruction memory read request.
REQ-005 imem_addr_o  output  32  request word address (byte address, [1:0]=0).
REQ-006 imem_ack_i  input  1  request accepted and data returned this cycle.
REQ-007 imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-008 redirect_i  input  1  one-cycle pulse: flush and restart fetch.
REQ-009 redirect_pc_i  input  32  new fetch address when redirect_i=1.
REQ-010 valid_ro  output  1  registered: pc_ro/inst_ro hold an instruction for decode.
REQ-011 ready_i  input  1  decode accepts; transfer when valid_ro & ready_i.
REQ-012 pc_ro  output  32  registered PC of presented instruction.
REQ-013 inst_ro  output  32  registered instruction word.

Function
REQ-014 Fetch PC pc_q SHALL advance by 4 per accepted ack; 32-bit wrap 0xFFFF_FFFC -> 0x0000_0000.
REQ-015 At most one request outstanding; imem_req_o and imem_addr_o SHALL stay stable from assertion until the cycle imem_ack_i=1 inclusive.
REQ-016 FSM states RUN, WAIT, DROP; RUN: no request outstanding; WAIT: request outstanding, data kept; DROP: request outstanding, data discarded.
REQ-017 RUN: imem_req_o=1 with imem_addr_o=pc_q iff buffer has a free entry (counting an entry freed by valid_ro & ready_i this cycle) and redirect_i=0; ack same cycle -> capture, stay RUN; no ack -> WAIT.
REQ-018 WAIT: imem_req_o=1; ack -> push {pc_q, imem_rdata_i}, pc_q+=4, -> RUN.
REQ-019 Redirect, highest priority: buffer emptied (valid_ro=0 next cycle), pc_q <= {redirect_pc_i[31:2],2'b00}; if a request is outstanding and not acked this cycle -> DROP, else -> RUN; data acked in the redirect cycle SHALL be discarded.
REQ-020 DROP: imem_req_o=1 at the old address; ack -> discard data, pc_q unchanged, -> RUN; a further redirect in DROP updates pc_q only.
REQ-021 Latency: ack in cycle N -> valid_ro=1 in N+1 with matching pc_ro/inst_ro (empty buffer).
REQ-022 valid_ro, pc_ro, inst_ro SHALL hold unchanged while valid_ro=1 and ready_i=0 (no redirect).
REQ-023 Instructions SHALL reach decode in PC order with no duplication or loss except on redirect.

Reset
REQ-024 rst=1 SHALL force: state RUN, pc_q=RESET_PC, buffer empty, valid_ro=0, pc_ro=0, inst_ro=0.
REQ-025 imem_req_o=0 while rst=1; first request (addr RESET_PC) in the first cycle after rst deasserts.
REQ-026 Reset mid-request SHALL abandon it; the late ack is the memory's responsibility and is not tracked.

Configuration
REQ-027 Macro FETCH_SKID_BUF_EN: when defined, buffer is 2 entries (output register + skid entry), sustaining one instruction per cycle with single-cycle ack under back-pressure release.
REQ-028 Without FETCH_SKID_BUF_EN: buffer is the output register only; new request issued only when valid_ro=0 or valid_ro & ready_i in that cycle.
REQ-029 Ports, reset values and redirect behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset release, RESET_PC=0x100, ack same cycle, ready_i=1 -> pc_ro 0x100,0x104,0x108 on consecutive cycles (buffered build: 1/cycle).
REQ-031 ready_i=0 for 5 cycles with valid_ro=1 -> pc_ro/inst_ro stable, imem_req_o=0 once buffer full, no instruction lost on release.
REQ-032 Ack delayed 3 cycles -> imem_addr_o stable for 4 cycles, valid_ro rises cycle after ack.
REQ-033 redirect_i to 0x2003 while request to 0x10 outstanding -> DROP, data for 0x10 never on inst_ro, next request addr 0x2000.
REQ-034 pc_q=0xFFFF_FFFC, ack -> next imem_addr_o=0x0000_0000.
REQ-035 rst asserted during WAIT -> valid_ro=0, imem_req_o=0 immediately; after release request addr RESET_PC.
